// File: rtl/arith_share_sched.sv
// rtl/arith_share_sched.sv - round-robin scheduler sharing one add/sub/halve/multiply unit
// Optional build macro: ARITH_SHARE_SCHED_CHECK_EN compiles in immediate assertions.
`timescale 1ns/1ps
module arith_share_sched #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [WIDTH*NREQ-1:0]   req_a,
    input  logic [WIDTH*NREQ-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [2*WIDTH-1:0]      rsp_data
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_HALF = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MULT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       grant;
    logic [IDW-1:0]       cand;
    logic                 found;
    logic                 accept;
    logic [1:0]           sel_op;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic                 mult_last;
    logic [WIDTH:0]       add_res;
    logic [WIDTH-1:0]     sub_res;
    logic [WIDTH-1:0]     half_res;
    logic [2*WIDTH-1:0]   exec_result;

    // Round-robin search starting at ptr and wrapping; first valid requester wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Steer the winner's opcode and operands; only used at the acceptance edge.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    assign accept    = (state == S_IDLE) && found && !rst;
    assign mult_last = (cnt == CW'(WIDTH - 1));
    assign rsp_valid = (state == S_RESP);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decode; the grant never depends on opcode or operands.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    req_ready[grant] = 1'b1;
                    state_nxt = (sel_op == OP_MUL) ? S_MULT : S_EXEC;
                end
            end
            S_EXEC: state_nxt = S_RESP;
            S_MULT: begin
                if (mult_last) begin
                    state_nxt = S_EXEC;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Single-cycle results; a finished multiply is passed through from the accumulator.
    always_comb begin
        add_res     = {1'b0, a_q} + {1'b0, b_q};
        sub_res     = a_q - b_q;
        half_res    = a_q >> 1;
        exec_result = '0;
        case (op_q)
            OP_ADD:  exec_result = {{(WIDTH-1){1'b0}}, add_res};
            OP_SUB:  exec_result = {{WIDTH{1'b0}}, sub_res};
            OP_HALF: exec_result = {{WIDTH{1'b0}}, half_res};
            default: exec_result = acc;
        endcase
    end

    // Capture at acceptance, shift-add multiply steps, and response register load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= sel_op;
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        rsp_id <= grant;
                        ptr    <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, sel_a};
                        mplier <= sel_b;
                        cnt    <= '0;
                    end
                end
                S_MULT: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= mult_last ? '0 : cnt + 1'b1;
                end
                S_EXEC: rsp_data <= exec_result;
                default: ;
            endcase
        end
    end

`ifdef ARITH_SHARE_SCHED_CHECK_EN
    logic               hold_q;
    logic [IDW-1:0]     id_prev;
    logic [2*WIDTH-1:0] data_prev;

    // Operand X/Z at acceptance, grant shape, and response stability under back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= 1'b0;
            id_prev   <= '0;
            data_prev <= '0;
        end else begin
            hold_q    <= rsp_valid && !rsp_ready;
            id_prev   <= rsp_id;
            data_prev <= rsp_data;
            if (accept) begin
                assert (^(sel_a ^ sel_b) !== 1'bx)
                    else $warning("arith_share_sched: X/Z operand at acceptance");
            end
            assert ($onehot0(req_ready))
                else $error("arith_share_sched: req_ready not zero-or-one-hot");
            if (hold_q) begin
                assert (rsp_id == id_prev && rsp_data == data_prev)
                    else $error("arith_share_sched: response changed while stalled");
            end
        end
    end
`endif

endmodule

// File: tb/tb_arith_share_sched.sv
// tb/tb_arith_share_sched.sv - self-checking bench for arith_share_sched
`timescale 1ns/1ps
module tb_arith_share_sched;
    localparam int W = 4;
    localparam int N = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [0:0]     rsp_id;
    logic [2*W-1:0] rsp_data;

    int total = 0;
    int bad   = 0;
    int cur_case = 0;

    arith_share_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached in case %0d", cur_case);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] vm;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         stall;
        int         eid;
        logic [7:0] edata;
        int         elat;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL case %0d %s: got %0h expected %0h", cur_case, name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int ai;
        int bi;
        int r;
        ai = int'(a);
        bi = int'(b);
        case (op)
            2'b00:   r = ai + bi;
            2'b01:   r = (ai - bi + 16) % 16;
            2'b10:   r = ai / 2;
            default: r = ai * bi;
        endcase
        return r[7:0];
    endfunction

    // One full transaction; entered and left just after a falling edge.
    task automatic serve(input logic [1:0] vm, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int stall, input int eid,
                         input logic [7:0] edata, input int elat);
        int lat;
        logic [1:0] egrant;
        egrant    = 2'b01 << eid;
        req_valid = vm;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        #1;
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("grant", 32'(req_ready), 32'(egrant));
        @(posedge clk);
        @(negedge clk);
        req_valid = vm & ~egrant;
        #1;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            check("busy_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        check("rsp_id", 32'(rsp_id), 32'(eid));
        check("rsp_data", 32'(rsp_data), 32'(edata));
        for (int s = 0; s < stall; s++) begin
            req_valid = 2'b11;
            #1;
            check("stall_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_id", 32'(rsp_id), 32'(eid));
            check("stall_data", 32'(rsp_data), 32'(edata));
        end
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        #1;
        check("hs_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        check("post_hs_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int mptr;
        int g;
        logic [1:0] vm;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] opi;
        logic [3:0] ai;
        logic [3:0] bi;

        vecs[0]  = '{2'b01, 4'b0000, 8'h0F, 8'h01, 0, 0, 8'h10, 1};
        vecs[1]  = '{2'b10, 4'b0100, 8'h30, 8'h50, 0, 1, 8'h0E, 1};
        vecs[2]  = '{2'b01, 4'b0010, 8'h09, 8'h0F, 0, 0, 8'h04, 1};
        vecs[3]  = '{2'b10, 4'b0000, 8'h20, 8'h30, 0, 1, 8'h05, 1};
        vecs[4]  = '{2'b11, 4'b0011, 8'h1F, 8'h1F, 0, 0, 8'hE1, 5};
        vecs[5]  = '{2'b11, 4'b0011, 8'h1F, 8'h1F, 0, 1, 8'h02, 1};
        vecs[6]  = '{2'b11, 4'b0000, 8'h87, 8'h81, 3, 0, 8'h08, 1};
        vecs[7]  = '{2'b11, 4'b0000, 8'h87, 8'h81, 3, 1, 8'h10, 1};
        vecs[8]  = '{2'b11, 4'b0000, 8'h87, 8'h81, 1, 0, 8'h08, 1};
        vecs[9]  = '{2'b11, 4'b0000, 8'h87, 8'h81, 0, 1, 8'h10, 1};
        vecs[10] = '{2'b10, 4'b1100, 8'hA0, 8'h70, 0, 1, 8'h46, 5};
        vecs[11] = '{2'b01, 4'b0001, 8'h00, 8'h00, 0, 0, 8'h00, 1};
        vecs[12] = '{2'b01, 4'b0011, 8'h03, 8'h05, 0, 0, 8'h0F, 5};
        vecs[13] = '{2'b11, 4'b1000, 8'hF0, 8'h00, 0, 1, 8'h07, 1};
        vecs[14] = '{2'b01, 4'b0011, 8'h00, 8'h0F, 0, 0, 8'h00, 5};
        vecs[15] = '{2'b11, 4'b0100, 8'h50, 8'h30, 0, 1, 8'h02, 1};
        vecs[16] = '{2'b01, 4'b0000, 8'h0F, 8'h0F, 0, 0, 8'h1E, 1};

        rst       = 1'b1;
        req_valid = 2'b11;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        cur_case = -1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        rst       = 1'b0;
        req_valid = 2'b00;

        for (int i = 0; i < 17; i++) begin
            cur_case = i;
            serve(vecs[i].vm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall,
                  vecs[i].eid, vecs[i].edata, vecs[i].elat);
        end

        // Reset in the second multiply cycle: no response, pointer back to 0.
        cur_case  = 100;
        req_valid = 2'b01;
        req_op    = 4'b0011;
        req_a     = 8'h0F;
        req_b     = 8'h0F;
        rsp_ready = 1'b1;
        #1;
        check("mul_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b11;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_data", 32'(rsp_data), 32'd0);
        check("rst_mid_id", 32'(rsp_id), 32'd0);
        rst       = 1'b0;
        req_valid = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        rsp_ready = 1'b0;
        serve(2'b11, 4'b0000, 8'h12, 8'h34, 0, 0, 8'h06, 1);

        // Random traffic against a round-robin model.
        mptr = 1;
        for (int it = 0; it < 200; it++) begin
            cur_case = 1000 + it;
            vm = 2'($urandom_range(0, 3));
            op = 4'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (vm == 2'b00) begin
                req_valid = vm;
                req_op    = op;
                req_a     = a;
                req_b     = b;
                #1;
                check("idle_no_grant", 32'(req_ready), 32'd0);
                @(negedge clk);
            end else begin
                g = vm[mptr] ? mptr : 1 - mptr;
                opi = op[2*g +: 2];
                ai  = a[4*g +: 4];
                bi  = b[4*g +: 4];
                serve(vm, op, a, b, $urandom_range(0, 2), g, ref_result(opi, ai, bi),
                      (opi == 2'b11) ? W + 1 : 1);
                mptr = (g + 1) % N;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arith_share_sched.md
# arith_share_sched

Round-robin scheduler that shares one arithmetic unit (add, subtract, halve, multiply) among `NREQ` requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block grants one requester at a time, runs the operation, and returns the result with the requester ID on a single shared response channel. Add, subtract and halve take a single cycle. Multiply is an iterative shift-add of `WIDTH` cycles. The block sits between the client blocks and the arithmetic datapath and replaces per-client arithmetic copies.

## Interface

**Parameters**
- `WIDTH`, 4: operand width.
- `NREQ`, 2: number of requesters, ≥2.

**Ports**
- `clk`, in, 1: clock. All logic is on the rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `req_valid`, in, `NREQ`: request valid, one bit per requester.
- `req_ready`, out, `NREQ`: grant/accept, one bit per requester.
- `req_op`, in, `2*NREQ`: opcode of requester i in bits `[2i+1:2i]`. Encoding: 00 ADD, 01 SUB, 10 HALF, 11 MUL.
- `req_a`, in, `WIDTH*NREQ`: operand A of requester i in bits `[WIDTH*i +: WIDTH]`.
- `req_b`, in, `WIDTH*NREQ`: operand B, packed the same way as `req_a`.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response accept.
- `rsp_id`, out, `$clog2(NREQ)`: index of the granted requester.
- `rsp_data`, out, `2*WIDTH`: result, zero-extended.

## Operation

**State machine:** IDLE, EXEC, MULT, RESP.

**IDLE**
- `req_ready` is one-hot on the arbiter winner, or all zero.
- Arbitration is round-robin: search from `ptr` upward, wrapping, for the first set `req_valid` bit.
- On `req_valid[g] & req_ready[g]`:
  - capture op, A, B and `g`;
  - set `ptr = (g+1) mod NREQ`;
  - go to MULT if op is 11, otherwise EXEC.

**EXEC** (one cycle): load `rsp_data`, then go to RESP.
- ADD: `A+B`, `WIDTH+1` bits keeping the carry.
- SUB: `(A-B) mod 2^WIDTH`.
- HALF: `A>>1`, logical.
- B is ignored for HALF.

**MULT** (exactly `WIDTH` cycles, counter 0..`WIDTH-1`)
- Initial values: `acc=0`, `mcand=A` zero-extended to `2*WIDTH`, `mplier=B`.
- Each cycle: if `mplier[0]`, `acc += mcand`; then `mcand <<= 1` and `mplier >>= 1`.
- After the last step, `rsp_data = acc` and the state goes to RESP.

**RESP**
- `rsp_valid=1`.
- `rsp_id` and `rsp_data` stay stable until `rsp_ready`.
- On the handshake, go to IDLE.

**Rules**
- `req_ready` is all zero outside IDLE.
- No request is accepted in the same cycle as the response handshake.
- A requester may drop `req_valid` before it is granted. This has no side effect.
- Requesters whose `req_valid` is low are skipped. `ptr` does not change when nothing is granted.
- `rsp_data` bits above the result width are 0.

**Reset:** while `rst` is high at an edge:
- state goes to IDLE;
- `ptr=0`;
- `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `req_ready=0`;
- the multiply counter clears.

Reset mid-operation abandons the operation and emits no response.

## Timing

- Acceptance edge is k.
- ADD, SUB, HALF: `rsp_valid` rises at edge k+1.
- MUL: `rsp_valid` rises at edge k+1+`WIDTH` (k+5 for `WIDTH=4`).
- Response handshake at edge r puts the block in IDLE after r. The next acceptance is no earlier than edge r+1.
- Best-case throughput is one non-MUL operation per 3 cycles.
- `req_ready` is combinational from state, `ptr` and `req_valid`. There is no combinational path from `req_op`, `req_a` or `req_b`.
- Worst-case wait for an asserted requester is `NREQ-1` services.

## Configuration

- **`ARITH_SHARE_SCHED_CHECK_EN` defined:** immediate assertions are compiled in.
  - `$warning` if the captured A or B contains X/Z at acceptance, checked with `^(A^B) !== 1'bx`.
  - `$error` if `req_ready` is not zero-or-one-hot.
  - `$error` if `rsp_id` or `rsp_data` changes while `rsp_valid & !rsp_ready`.
- **Undefined:** no assertion code is compiled. Cycle behaviour is identical in both cases.

## Test plan

1. **ADD with carry:** req0 ADD A=4'hF, B=4'h1 → `rsp_valid` at edge k+1, `rsp_id=0`, `rsp_data=8'h10`.
2. **SUB wrap-around:** req1 SUB A=4'h3, B=4'h5 → `rsp_data=8'h0E`, `rsp_id=1`.
3. **HALF:** req0 HALF A=4'h9, B=4'hF → `rsp_data=8'h04`.
4. **MUL and arbitration order:**
   - req0 MUL A=4'hF, B=4'hF → `rsp_valid` exactly 5 edges after acceptance, `rsp_data=8'hE1`.
   - Hold req1 valid throughout → req1 is granted next.
5. **Round-robin with back-pressure:**
   - Both requesters issue ADD continuously → grants alternate 0,1,0,1.
   - Hold `rsp_ready` low for 3 cycles → `rsp_data` and `rsp_id` stay stable and `req_ready` stays 0.
6. **Reset during multiply:** assert `rst` in the 2nd MULT cycle → next cycle `rsp_valid=0` with no response; then both requesters valid → req0 is granted (`ptr=0`).
